// File: rtl/tx_status_fifo_mq.sv
// TX-status FIFO: logs one packed status word per TX attempt, with an occupancy/drop status word and a threshold IRQ.
// Optional macro TX_STATUS_TIMESTAMP_EN stores tsf with each entry and latches the head's tsf on every pop.
module tx_status_fifo_mq #(
  parameter int            DEPTH      = 64,
  parameter int            AW         = 5,
  parameter logic [AW-1:0] RD_ADDR    = 'h16,
  parameter logic [AW-1:0] STAT_ADDR  = 'h17,
  parameter int            IRQ_THRESH = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          slv_reg_rden,
  input  logic [AW-1:0] axi_araddr_core,
  input  logic          tx_try_complete,
  input  logic [9:0]    num_slot_random,
  input  logic [3:0]    cw,
  input  logic [4:0]    tx_status,
  input  logic [1:0]    linux_prio,
  input  logic [1:0]    tx_queue_idx,
  input  logic [9:0]    tx_pkt_sn,
`ifdef TX_STATUS_TIMESTAMP_EN
  input  logic [31:0]   tsf,
  output logic [31:0]   tx_status_ts_out,
`endif
  output logic [31:0]   tx_status_out,
  output logic [31:0]   tx_status_stat,
  output logic          tx_status_irq
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);
`ifdef TX_STATUS_TIMESTAMP_EN
  localparam int EW = 64;
`else
  localparam int EW = 32;
`endif

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [3:0]    cw_d0_q, cw_d0_d, cw_d1_q, cw_d1_d;
  logic          wr_v_q, wr_v_d;
  logic [EW-1:0] word_q, word_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [7:0]    drop_q, drop_d;
  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] head;
  logic [31:0]   pkt;
  logic [7:0]    occ8;
  logic          empty, full, pop, wr_en, drop, stat_clr;
`ifdef TX_STATUS_TIMESTAMP_EN
  logic [31:0]   ts_out_q, ts_out_d;
`endif

  assign head     = mem[rd_ptr_q];
  assign empty    = (occ_q == '0);
  assign full     = (occ_q == CW'(DEPTH));
  assign pop      = slv_reg_rden && (axi_araddr_core == RD_ADDR) && !empty;
  assign stat_clr = slv_reg_rden && (axi_araddr_core == STAT_ADDR);
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign wr_en    = wr_v_q && (!full || pop);
  assign drop     = wr_v_q && full && !pop;
  assign pkt      = {cw_d1_q, num_slot_random[8:0], linux_prio, tx_queue_idx, tx_pkt_sn, tx_status};

  always_comb begin
    cw_d0_d  = cw;
    cw_d1_d  = cw_d0_q + {3'b000, num_slot_random[9]};
    wr_v_d   = tx_try_complete;
`ifdef TX_STATUS_TIMESTAMP_EN
    word_d   = {tsf, pkt};
    ts_out_d = pop ? head[63:32] : ts_out_q;
`else
    word_d   = pkt;
`endif
    wr_ptr_d = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    occ_d    = occ_q + CW'(wr_en) - CW'(pop);
    if (stat_clr) begin
      drop_d = {7'b0, drop};
    end else if (drop) begin
      drop_d = sat_inc8(drop_q);
    end else begin
      drop_d = drop_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cw_d0_q  <= '0;
      cw_d1_q  <= '0;
      wr_v_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      drop_q   <= '0;
`ifdef TX_STATUS_TIMESTAMP_EN
      ts_out_q <= '0;
`endif
    end else begin
      cw_d0_q  <= cw_d0_d;
      cw_d1_q  <= cw_d1_d;
      wr_v_q   <= wr_v_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      drop_q   <= drop_d;
`ifdef TX_STATUS_TIMESTAMP_EN
      ts_out_q <= ts_out_d;
`endif
    end
  end

  // Datapath registers carry no reset; wr_v_q qualifies them.
  always_ff @(posedge clk) begin
    word_q <= word_d;
    if (wr_en) begin
      mem[wr_ptr_q] <= word_q;
    end
  end

  if (CW >= 8) begin : g_occ_trunc
    assign occ8 = occ_q[7:0];
  end else begin : g_occ_ext
    assign occ8 = {{(8 - CW){1'b0}}, occ_q};
  end

  assign tx_status_out  = empty ? 32'hFFFF_FFFF : head[31:0];
  assign tx_status_stat = {14'b0, empty, full, drop_q, occ8};
  assign tx_status_irq  = (occ_q >= CW'(IRQ_THRESH));
`ifdef TX_STATUS_TIMESTAMP_EN
  assign tx_status_ts_out = ts_out_q;
`endif

endmodule

// File: tb/tb_tx_status_fifo_mq.sv
// Self-checking bench for tx_status_fifo_mq: randomized traffic against a queue-based reference model.
module tb_tx_status_fifo_mq;
  localparam int         DEPTH = 64;
  localparam int         THR   = 16;
  localparam logic [4:0] RD    = 5'h16;
  localparam logic [4:0] ST    = 5'h17;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        slv_reg_rden = 1'b0;
  logic [4:0]  axi_araddr_core = '0;
  logic        tx_try_complete = 1'b0;
  logic [9:0]  num_slot_random = '0;
  logic [3:0]  cw = '0;
  logic [4:0]  tx_status = '0;
  logic [1:0]  linux_prio = '0;
  logic [1:0]  tx_queue_idx = '0;
  logic [9:0]  tx_pkt_sn = '0;
  logic [31:0] tx_status_out;
  logic [31:0] tx_status_stat;
  logic        tx_status_irq;

  int checks = 0;
  int failures = 0;

  // Reference model: FIFO contents, one write in flight, drop counter.
  logic [31:0] mq[$];
  bit          pend_v = 1'b0;
  logic [31:0] pend_w = '0;
  int          mdrop = 0;

  always #5 clk = ~clk;

  tx_status_fifo_mq #(
    .DEPTH(DEPTH), .AW(5), .RD_ADDR(RD), .STAT_ADDR(ST), .IRQ_THRESH(THR)
  ) dut (
    .clk(clk), .rstn(rstn), .slv_reg_rden(slv_reg_rden), .axi_araddr_core(axi_araddr_core),
    .tx_try_complete(tx_try_complete), .num_slot_random(num_slot_random), .cw(cw),
    .tx_status(tx_status), .linux_prio(linux_prio), .tx_queue_idx(tx_queue_idx),
    .tx_pkt_sn(tx_pkt_sn), .tx_status_out(tx_status_out), .tx_status_stat(tx_status_stat),
    .tx_status_irq(tx_status_irq)
  );

  // Fields are held stable around a pulse, so the cw field is simply cw + nsr[9] mod 16.
  function automatic logic [31:0] pack_fields();
    logic [3:0] c;
    c = cw + {3'b000, num_slot_random[9]};
    return {c, num_slot_random[8:0], linux_prio, tx_queue_idx, tx_pkt_sn, tx_status};
  endfunction

  function automatic logic [31:0] exp_out();
    if (mq.size() == 0) return 32'hFFFF_FFFF;
    return mq[0];
  endfunction

  function automatic logic [31:0] exp_stat();
    int n;
    n = mq.size();
    return {14'b0, (n == 0), (n == DEPTH), 8'(mdrop), 8'(n)};
  endfunction

  function automatic logic exp_irq();
    return mq.size() >= THR;
  endfunction

  task automatic rand_fields(input bit keep_cw);
    if (!keep_cw) begin
      cw = 4'($urandom);
      num_slot_random[9] = 1'($urandom);
    end
    num_slot_random[8:0] = 9'($urandom);
    tx_status    = 5'($urandom);
    linux_prio   = 2'($urandom);
    tx_queue_idx = 2'($urandom);
    tx_pkt_sn    = 10'($urandom);
  endtask

  // One clock: drive inputs, advance the model across the edge, sample 1 ns after the edge.
  task automatic step(input bit pulse, input bit rd, input logic [4:0] addr);
    bit pop_m, can_wr, dr;
    tx_try_complete = pulse;
    slv_reg_rden    = rd;
    axi_araddr_core = addr;
    pop_m  = rd && (addr == RD) && (mq.size() > 0);
    can_wr = (mq.size() < DEPTH) || pop_m;
    dr     = pend_v && !can_wr;
    if (pop_m) void'(mq.pop_front());
    if (pend_v && can_wr) mq.push_back(pend_w);
    if (rd && addr == ST) mdrop = dr ? 1 : 0;
    else if (dr && mdrop < 255) mdrop++;
    pend_v = pulse;
    pend_w = pack_fields();
    @(posedge clk);
    #1;
    tx_try_complete = 1'b0;
    slv_reg_rden    = 1'b0;
  endtask

  task automatic push_entry(input bit rnd);
    if (rnd) rand_fields(1'b0);
    step(1'b0, 1'b0, 5'h00);
    step(1'b0, 1'b0, 5'h00);
    step(1'b1, 1'b0, 5'h00);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    step(1'b0, 1'b0, 5'h00);
    checks++; if (tx_status_out !== 32'hFFFF_FFFF) begin failures++; $display("FAIL reset_out got=%h exp=%h", tx_status_out, 32'hFFFF_FFFF); end
    checks++; if (tx_status_stat !== 32'h0002_0000) begin failures++; $display("FAIL reset_stat got=%h exp=%h", tx_status_stat, 32'h0002_0000); end
    checks++; if (tx_status_irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", tx_status_irq); end
  endtask

  task automatic test_single();
    logic [31:0] w;
    cw = 4'd3; num_slot_random = 10'h205; tx_status = 5'h01;
    tx_pkt_sn = 10'h155; tx_queue_idx = 2'd2; linux_prio = 2'd1;
    w = {4'd4, 9'h005, 2'd1, 2'd2, 10'h155, 5'h01};
    step(1'b0, 1'b0, 5'h00);
    step(1'b0, 1'b0, 5'h00);
    step(1'b1, 1'b0, 5'h00);
    checks++; if (tx_status_out !== 32'hFFFF_FFFF) begin failures++; $display("FAIL single_t1 got=%h exp=%h", tx_status_out, 32'hFFFF_FFFF); end
    step(1'b0, 1'b0, 5'h00);
    checks++; if (tx_status_out !== w) begin failures++; $display("FAIL single_t2 got=%h exp=%h", tx_status_out, w); end
    checks++; if (tx_status_stat !== 32'h0000_0001) begin failures++; $display("FAIL single_stat got=%h exp=%h", tx_status_stat, 32'h0000_0001); end
    step(1'b0, 1'b1, RD);
    checks++; if (tx_status_out !== 32'hFFFF_FFFF) begin failures++; $display("FAIL single_pop got=%h exp=%h", tx_status_out, 32'hFFFF_FFFF); end
    checks++; if (tx_status_stat !== 32'h0002_0000) begin failures++; $display("FAIL single_empty got=%h exp=%h", tx_status_stat, 32'h0002_0000); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH + 3; i++) push_entry(1'b1);
    step(1'b0, 1'b0, 5'h00);
    checks++; if (tx_status_stat !== 32'h0001_0340) begin failures++; $display("FAIL ovf_stat got=%h exp=%h", tx_status_stat, 32'h0001_0340); end
    step(1'b0, 1'b1, ST);
    checks++; if (tx_status_stat !== 32'h0001_0040) begin failures++; $display("FAIL ovf_clear got=%h exp=%h", tx_status_stat, 32'h0001_0040); end
    for (int i = 0; i < 300; i++) step(1'b1, 1'b0, 5'h00);
    step(1'b0, 1'b0, 5'h00);
    checks++; if (tx_status_stat !== 32'h0001_FF40) begin failures++; $display("FAIL ovf_sat got=%h exp=%h", tx_status_stat, 32'h0001_FF40); end
    step(1'b1, 1'b0, 5'h00);
    step(1'b0, 1'b1, ST);
    checks++; if (tx_status_stat !== 32'h0001_0140) begin failures++; $display("FAIL ovf_clr_drop got=%h exp=%h", tx_status_stat, 32'h0001_0140); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (tx_status_out !== exp_out()) begin failures++; $display("FAIL ovf_order[%0d] got=%h exp=%h", i, tx_status_out, exp_out()); end
      step(1'b0, 1'b1, RD);
    end
    step(1'b0, 1'b1, ST);
    checks++; if (tx_status_stat !== 32'h0002_0000) begin failures++; $display("FAIL ovf_drained got=%h exp=%h", tx_status_stat, 32'h0002_0000); end
  endtask

  task automatic test_irq();
    for (int i = 0; i < THR; i++) begin
      push_entry(1'b1);
      checks++; if (tx_status_irq !== exp_irq()) begin failures++; $display("FAIL irq_fill[%0d] got=%b exp=%b", i, tx_status_irq, exp_irq()); end
    end
    step(1'b0, 1'b0, 5'h00);
    checks++; if (tx_status_irq !== 1'b1) begin failures++; $display("FAIL irq_at_thresh got=%b exp=1", tx_status_irq); end
    step(1'b0, 1'b1, RD);
    checks++; if (tx_status_irq !== 1'b0) begin failures++; $display("FAIL irq_after_pop got=%b exp=0", tx_status_irq); end
    for (int i = 0; i < THR - 1; i++) step(1'b0, 1'b1, RD);
    checks++; if (tx_status_stat !== exp_stat()) begin failures++; $display("FAIL irq_drain got=%h exp=%h", tx_status_stat, exp_stat()); end
  endtask

  task automatic test_full_wr_pop();
    for (int i = 0; i < DEPTH; i++) push_entry(1'b1);
    step(1'b0, 1'b0, 5'h00);
    checks++; if (tx_status_stat !== 32'h0001_0040) begin failures++; $display("FAIL fwp_full got=%h exp=%h", tx_status_stat, 32'h0001_0040); end
    for (int k = 0; k < 4; k++) begin
      push_entry(1'b1);
      step(1'b0, 1'b1, RD);
      checks++; if (tx_status_stat !== 32'h0001_0040) begin failures++; $display("FAIL fwp_stat[%0d] got=%h exp=%h", k, tx_status_stat, 32'h0001_0040); end
      checks++; if (tx_status_out !== exp_out()) begin failures++; $display("FAIL fwp_head[%0d] got=%h exp=%h", k, tx_status_out, exp_out()); end
    end
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (tx_status_out !== exp_out()) begin failures++; $display("FAIL fwp_order[%0d] got=%h exp=%h", i, tx_status_out, exp_out()); end
      step(1'b0, 1'b1, RD);
    end
    checks++; if (tx_status_out !== 32'hFFFF_FFFF) begin failures++; $display("FAIL fwp_empty got=%h exp=%h", tx_status_out, 32'hFFFF_FFFF); end
  endtask

  task automatic test_random();
    logic [4:0] a;
    int r;
    rand_fields(1'b0);
    step(1'b0, 1'b0, 5'h00);
    step(1'b0, 1'b0, 5'h00);
    for (int i = 0; i < 600; i++) begin
      rand_fields(1'b1);
      r = int'($urandom_range(0, 3));
      a = (r < 2) ? RD : ((r == 2) ? ST : 5'h03);
      step($urandom_range(0, 99) < 60, $urandom_range(0, 1) == 1, a);
      checks++; if (tx_status_out !== exp_out()) begin failures++; $display("FAIL rnd_out[%0d] got=%h exp=%h", i, tx_status_out, exp_out()); end
      checks++; if (tx_status_stat !== exp_stat()) begin failures++; $display("FAIL rnd_stat[%0d] got=%h exp=%h", i, tx_status_stat, exp_stat()); end
      checks++; if (tx_status_irq !== exp_irq()) begin failures++; $display("FAIL rnd_irq[%0d] got=%b exp=%b", i, tx_status_irq, exp_irq()); end
    end
  endtask

  task automatic test_pop_empty_reset();
    for (int i = 0; i < DEPTH + 4 && (mq.size() > 0 || pend_v); i++) step(1'b0, 1'b1, RD);
    step(1'b0, 1'b1, ST);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, RD);
      checks++; if (tx_status_out !== 32'hFFFF_FFFF) begin failures++; $display("FAIL empty_pop_out[%0d] got=%h exp=%h", i, tx_status_out, 32'hFFFF_FFFF); end
      checks++; if (tx_status_stat !== 32'h0002_0000) begin failures++; $display("FAIL empty_pop_stat[%0d] got=%h exp=%h", i, tx_status_stat, 32'h0002_0000); end
    end
    rand_fields(1'b0);
    step(1'b0, 1'b0, 5'h00);
    step(1'b0, 1'b0, 5'h00);
    for (int i = 0; i < 6; i++) begin
      rand_fields(1'b1);
      step(1'b1, 1'b0, 5'h00);
    end
    checks++; if (tx_status_stat !== exp_stat()) begin failures++; $display("FAIL burst_stat got=%h exp=%h", tx_status_stat, exp_stat()); end
    rstn = 1'b0;
    #1;
    mq.delete();
    pend_v = 1'b0;
    mdrop = 0;
    checks++; if (tx_status_out !== 32'hFFFF_FFFF) begin failures++; $display("FAIL midrst_out got=%h exp=%h", tx_status_out, 32'hFFFF_FFFF); end
    checks++; if (tx_status_stat !== 32'h0002_0000) begin failures++; $display("FAIL midrst_stat got=%h exp=%h", tx_status_stat, 32'h0002_0000); end
    checks++; if (tx_status_irq !== 1'b0) begin failures++; $display("FAIL midrst_irq got=%b exp=0", tx_status_irq); end
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    step(1'b0, 1'b0, 5'h00);
    checks++; if (tx_status_stat !== 32'h0002_0000) begin failures++; $display("FAIL postrst_stat got=%h exp=%h", tx_status_stat, 32'h0002_0000); end
    push_entry(1'b1);
    step(1'b0, 1'b0, 5'h00);
    checks++; if (tx_status_out !== exp_out()) begin failures++; $display("FAIL postrst_out got=%h exp=%h", tx_status_out, exp_out()); end
    checks++; if (tx_status_stat !== 32'h0000_0001) begin failures++; $display("FAIL postrst_occ got=%h exp=%h", tx_status_stat, 32'h0000_0001); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_irq();
    test_full_wr_pop();
    test_random();
    test_pop_empty_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
